cnt_seq_checker: RTL and testbench

Passive monitor at the receiving end of the Cont8b counter interface. It samples the counter's enable, its reset and its 8-bit Qdata output. It checks every sample against the value the counter must produce, and reports lock, per-event error pulses and a saturating error count. Instantiated beside each Cont8b in simulation and in board self-test.

---
 rtl/cnt_chk_pkg.sv | 24 ++
 rtl/cnt_chk_satcnt.sv | 36 +++
 rtl/cnt_seq_checker.sv | 98 +++++++++
 tb/tb_cnt_seq_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared types and the counter prediction rule for the Cont8b sequence checker.
package cnt_chk_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int ERR_W_DEF = 8;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_e;

  // Value the counter must show given the previous sample and the current crst.
  // Computed at MAX_W bits; callers truncate to WIDTH, which is the mod 2^WIDTH wrap.
  function automatic logic [MAX_W-1:0] next_expected(input logic [MAX_W-1:0] prev_q,
                                                     input logic             prev_ena,
                                                     input logic             prev_crst,
                                                     input logic             cur_crst);
    logic [MAX_W-1:0] nxt;
    if (!cur_crst)                    nxt = '0;
    else if (!prev_crst && !prev_ena) nxt = '0;
    else if (prev_ena)                nxt = prev_q + MAX_W'(1);
    else                              nxt = prev_q;
    return nxt;
  endfunction

endpackage

// File: rtl/cnt_chk_satcnt.sv
// Saturating counter with synchronous clear; an increment in the same cycle as a
// clear restarts the count at one.
module cnt_chk_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] base;

  always_comb begin
    cnt_d = cnt_q;
    base  = cnt_q;
    if (inc_i) begin
      base  = clr_i ? '0 : cnt_q;
      cnt_d = (base == MAX) ? base : base + W'(1);
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// Passive monitor of a Cont8b counter: predicts each Qdata sample, reports lock,
// per-mismatch error pulses and a saturating error count.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             crst,
  input  logic [WIDTH-1:0] Qdata,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] exp_q
);

  localparam int MC_W = 4;

  state_e           state_q, state_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] exp_val_q, exp_d;
  logic [WIDTH-1:0] prev_q_q;
  logic             prev_ena_q, prev_crst_q;
  logic [WIDTH-1:0] exp_cur;
  logic             mismatch;

  always_comb begin
    exp_cur  = WIDTH'(next_expected(MAX_W'(prev_q_q), prev_ena_q, prev_crst_q, crst));
    // Case inequality so that X/Z on Qdata is always judged a mismatch.
    mismatch = (Qdata !== exp_cur);
    // Prediction for the next sample assumes the counter is out of reset then.
    exp_d    = WIDTH'(next_expected(MAX_W'(Qdata), ena, crst, 1'b1));
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: state_d = SYNC;
      SYNC: begin
        if (mismatch) begin
          mcnt_d = '0;
        end else if (mcnt_q == MC_W'(LOCK_LEN - 1)) begin
          mcnt_d  = '0;
          state_d = LOCKED;
        end else begin
          mcnt_d = mcnt_q + MC_W'(1);
        end
      end
      LOCKED: begin
        if (mismatch) begin
          err_d   = 1'b1;
          mcnt_d  = '0;
          state_d = SYNC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcnt_q    <= '0;
      err_q     <= 1'b0;
      exp_val_q <= '0;
    end else begin
      state_q   <= state_d;
      mcnt_q    <= mcnt_d;
      err_q     <= err_d;
      exp_val_q <= exp_d;
    end
  end

  // Sample history only feeds the prediction; IDLE refills it before any compare.
  always_ff @(posedge clk) begin
    prev_q_q    <= Qdata;
    prev_ena_q  <= ena;
    prev_crst_q <= crst;
  end

  cnt_chk_satcnt #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (clr_err),
    .inc_i (err_d),
    .cnt_o (err_cnt)
  );

  assign locked = (state_q == LOCKED);
  assign err    = err_q;
  assign exp_q  = exp_val_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Randomised and directed bench for cnt_seq_checker against a behavioural model.
module tb_cnt_seq_checker;

  localparam int WIDTH    = 8;
  localparam int LOCK_LEN = 4;
  localparam int ERR_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b0;
  logic             crst = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] Qdata = '0;
  logic             locked, err;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] exp_q;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  cnt_seq_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .crst    (crst),
    .Qdata   (Qdata),
    .clr_err (clr_err),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .exp_q   (exp_q)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h, at time %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural model: remembers the last sample and applies the counter rules.
  logic             m_run = 1'b0, m_locked = 1'b0, m_err = 1'b0;
  int               m_mc = 0;
  logic [ERR_W-1:0] m_cnt = '0;
  logic [WIDTH-1:0] m_exp = '0, mpq = '0, expv;
  logic             mpe = 1'b0, mpc = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_mc = 0; m_cnt = '0; m_exp = '0;
    end else begin
      if (!crst)             expv = 8'd0;
      else if (!mpc && !mpe) expv = 8'd0;
      else if (mpe)          expv = mpq + 8'd1;
      else                   expv = mpq;
      m_err = 1'b0;
      if (!m_run) begin
        m_run = 1'b1;
      end else if (Qdata === expv) begin
        if (!m_locked) begin
          m_mc++;
          if (m_mc == LOCK_LEN) begin m_locked = 1'b1; m_mc = 0; end
        end
      end else begin
        if (m_locked) m_err = 1'b1;
        m_locked = 1'b0;
        m_mc = 0;
      end
      if (m_err) begin
        if (clr_err)             m_cnt = 8'd1;
        else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else if (clr_err) begin
        m_cnt = 8'd0;
      end
      m_exp = (!crst && !ena) ? 8'd0 : (ena ? Qdata + 8'd1 : Qdata);
      mpq = Qdata; mpe = ena; mpc = crst;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("locked",  32'(locked),  32'(m_locked));
      check("err",     32'(err),     32'(m_err));
      check("err_cnt", 32'(err_cnt), 32'(m_cnt));
      check("exp_q",   32'(exp_q),   32'(m_exp));
    end
  end

  // Cont8b stand-in: gq is the true counter value, independent of injected faults.
  logic [WIDTH-1:0] gq = '0;
  logic             ge = 1'b0, gc = 1'b0;

  task automatic cyc(input logic e, input logic c, input logic clr, input int flt);
    logic [WIDTH-1:0] nq;
    @(negedge clk); #1;
    if (!c)              nq = 8'd0;
    else if (!gc && !ge) nq = 8'd0;
    else if (ge)         nq = gq + 8'd1;
    else                 nq = gq;
    gq = nq; ge = e; gc = c;
    ena = e; crst = c; clr_err = clr;
    if (flt == 1)      Qdata = nq ^ 8'h02;
    else if (flt == 2) Qdata = 'x;
    else               Qdata = nq;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    chk_on = 1'b1;
    check("reset_locked",  32'(locked),  32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    check("reset_exp_q",   32'(exp_q),   32'd0);
    @(posedge clk);

    // Release reset and count up from 0: IDLE edge plus four matches.
    cyc(1, 1, 0, 0);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) cyc(1, 1, 0, 0);
      after_edge();
      if (i == 4) check("lock_not_yet", 32'(locked), 32'd0);
    end
    check("lock_edge5",  32'(locked), 32'd1);
    check("exp_after5",  32'(exp_q),  32'h05);

    // Enable toggling: holds must be predicted as holds.
    for (int r = 0; r < 4; r++) begin
      repeat (3) cyc(1, 1, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
    end
    after_edge();
    check("hold_exp_eq_q", 32'(exp_q), 32'(Qdata));
    check("hold_locked",   32'(locked), 32'd1);

    // Single bad sample 0x37 where 0x35 is due.
    for (int i = 0; i < 300 && gq != 8'h34; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    after_edge();
    check("glitch_q",       32'(Qdata),   32'h37);
    check("glitch_err",     32'(err),     32'd1);
    check("glitch_err_cnt", 32'(err_cnt), 32'd1);
    check("glitch_unlock",  32'(locked),  32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 1, 0, 0);
      after_edge();
      if (i == 1) check("glitch_err_once", 32'(err), 32'd0);
      if (i == 4) check("relock_not_yet", 32'(locked), 32'd0);
    end
    check("relock", 32'(locked), 32'd1);

    // Wrap through 0xFF -> 0x00.
    for (int i = 0; i < 300 && gq != 8'hFC; i++) cyc(1, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 0);
    after_edge();
    check("wrap_q",       32'(Qdata),   32'h02);
    check("wrap_locked",  32'(locked),  32'd1);
    check("wrap_err_cnt", 32'(err_cnt), 32'd1);

    // Counter reset pulse while locked, then a long hold at zero.
    repeat (2) cyc(0, 0, 0, 0);
    repeat (25) cyc(0, 1, 0, 0);
    after_edge();
    check("crst_exp_zero", 32'(exp_q),  32'd0);
    check("crst_locked",   32'(locked), 32'd1);

    // Random enables, counter resets, clears and faults (one X sample).
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) != 0),
          1'($urandom_range(0, 29) == 0),
          (i == 200) ? 2 : (($urandom_range(0, 19) == 0) ? 1 : 0));
    end

    // Clear alone, then drive the count into saturation.
    cyc(1, 1, 1, 0);
    after_edge();
    check("clr_alone", 32'(err_cnt), 32'd0);
    repeat (6) cyc(1, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 0, 1);
      repeat (6) cyc(1, 1, 0, 0);
    end
    after_edge();
    check("saturated", 32'(err_cnt), 32'd255);
    cyc(1, 1, 1, 1);
    after_edge();
    check("clr_with_err_cnt", 32'(err_cnt), 32'd1);
    check("clr_with_err_err", 32'(err),     32'd1);

    // Asynchronous reset between edges while locked.
    repeat (8) cyc(1, 1, 0, 0);
    after_edge();
    check("pre_rst_locked", 32'(locked), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_locked",  32'(locked),  32'd0);
    check("async_err",     32'(err),     32'd0);
    check("async_err_cnt", 32'(err_cnt), 32'd0);
    check("async_exp_q",   32'(exp_q),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
